lpc_record_packer: RTL

- Sits directly downstream of the LPC cycle decoder in the sniffer.
- Captures each decoded transaction (cycle type/direction, 32-bit address, data byte) on the rising edge of the decoder's completion strobe.
- Buffers captured transactions in a FIFO and serialises each one as a fixed 6-byte record over a valid/ready byte stream, which feeds the UART transmitter.
- Counts and flags transactions dropped due to FIFO overflow.

---
 rtl/lpc_record_packer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/lpc_record_packer.sv
// LPC record packer: captures decoded LPC transactions on a strobe edge,
// queues them and streams each one as a 6-byte record.
module lpc_record_packer #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 8
) (
    input  logic                     lpc_clock,
    input  logic                     lpc_reset,
    input  logic [3:0]               in_cyctype_dir,
    input  logic [31:0]              in_addr,
    input  logic [7:0]               in_data,
    input  logic                     in_clock_enable,
    output logic [7:0]               out_byte,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 45;
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              r_prev_ce;
    logic              r_lost;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop;
    state_t            r_state;
    logic [2:0]        r_idx;
    logic [EW-1:0]     r_hold;
    logic [7:0]        r_out_byte;
    logic              r_out_valid;

    logic              w_capture;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_accept;
    logic [EW-1:0]     w_entry;
    logic [EW-1:0]     w_head;

    // Entry layout: {lost, cyctype_dir[3:0], addr[31:0], data[7:0]}
    function automatic logic [7:0] rec_byte(input logic [EW-1:0] e,
                                            input logic [2:0]    i);
        logic [7:0] b;
        case (i)
            3'd0:    b = {e[43:40], 3'b000, e[44]};
            3'd1:    b = e[39:32];
            3'd2:    b = e[31:24];
            3'd3:    b = e[23:16];
            3'd4:    b = e[15:8];
            default: b = e[7:0];
        endcase
        return b;
    endfunction

    assign w_capture = in_clock_enable & ~r_prev_ce;
    assign w_full    = (r_count == L_FULL);
    assign w_empty   = (r_count == '0);
    assign w_push    = w_capture & ~w_full;
    assign w_pop     = (r_state == S_IDLE) & ~w_empty;
    assign w_accept  = r_out_valid & out_ready;
    assign w_entry   = {r_lost, in_cyctype_dir, in_addr, in_data};
    assign w_head    = r_mem[r_rptr];

    always_ff @(posedge lpc_clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            r_prev_ce  <= 1'b1;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_lost     <= 1'b0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else begin
            r_prev_ce <= in_clock_enable;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
                r_lost <= 1'b0;
            end
            // Full is judged before this cycle's pop, so a pop never rescues it
            if (w_capture && w_full) begin
                r_overflow <= 1'b1;
                r_lost     <= 1'b1;
                if (r_drop != '1) begin
                    r_drop <= r_drop + 1'b1;
                end
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_hold      <= '0;
            r_out_byte  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_hold      <= w_head;
                        r_idx       <= '0;
                        r_out_byte  <= rec_byte(w_head, 3'd0);
                        r_out_valid <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_accept) begin
                        if (r_idx == 3'd5) begin
                            r_out_valid <= 1'b0;
                            r_out_byte  <= '0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_idx      <= r_idx + 3'd1;
                            r_out_byte <= rec_byte(r_hold, r_idx + 3'd1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_byte   = r_out_byte;
    assign out_valid  = r_out_valid;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop;

endmodule
